// File: rtl/next_pc_sequencer.sv
// Next-PC generator with boot/run/halt FSM and optional return-address stack.
// Define PC_RAS_EN to build the RAS; without it call acts as jump and ret is ignored.
module next_pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter int               PC_INC       = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             stall,
    input  logic             halt,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    output logic [WIDTH-1:0] new_pc,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] seq_pc;

    assign seq_pc = pc + WIDTH'(PC_INC);

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = RAS_DEPTH[PW:0];

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      cnt, cnt_next;
    logic             empty_q, full_q, err_q;
    logic             push, pop, err_set;
    logic [WIDTH-1:0] top;

    // ptr is the next free slot; when full it also addresses the oldest entry
    assign top = stack[ptr - PW'(1)];
`else
    logic unused_ret;
    assign unused_ret = ret;
`endif

    always_comb begin
        state_next = state;
        new_pc     = pc;
`ifdef PC_RAS_EN
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
`endif
        if (rst) begin
            new_pc     = RESET_VECTOR;
            state_next = BOOT;
        end else begin
            unique case (state)
                BOOT: begin
                    new_pc     = RESET_VECTOR;
                    state_next = RUN;
                end
                RUN: begin
                    if (halt) begin
                        new_pc     = pc;
                        state_next = HALTED;
                    end else if (stall) begin
                        new_pc = pc;
`ifdef PC_RAS_EN
                    end else if (ret) begin
                        if (cnt == '0) begin
                            new_pc  = seq_pc;
                            err_set = 1'b1;
                        end else begin
                            new_pc = top;
                            pop    = 1'b1;
                        end
                    end else if (call) begin
                        new_pc  = jump_target;
                        push    = 1'b1;
                        err_set = (cnt == FULL_CNT);
`else
                    end else if (call) begin
                        new_pc = jump_target;
`endif
                    end else if (jump) begin
                        new_pc = jump_target;
                    end else if (branch_taken) begin
                        new_pc = branch_target;
                    end else begin
                        new_pc = seq_pc;
                    end
                end
                HALTED: new_pc = pc;
                default: begin
                    new_pc     = RESET_VECTOR;
                    state_next = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    assign halted = !rst && (state == HALTED);

`ifdef PC_RAS_EN
    always_comb begin
        cnt_next = cnt;
        if (push && (cnt != FULL_CNT)) cnt_next = cnt + 1'b1;
        else if (pop)                  cnt_next = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (push)     ptr <= ptr + PW'(1);
            else if (pop) ptr <= ptr - PW'(1);
            cnt     <= cnt_next;
            empty_q <= (cnt_next == '0);
            full_q  <= (cnt_next == FULL_CNT);
            if (err_set) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack[ptr] <= seq_pc;
    end

    assign ras_empty = rst | empty_q;
    assign ras_full  = !rst & full_q;
    assign ras_err   = !rst & err_q;
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Testbench for next_pc_sequencer: directed scenarios plus randomized run
// against a queue-based reference model of the sequencing rules.
module tb_next_pc_sequencer;

`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk, rst, stall, halt, branch_taken, jump, call, ret;
    logic [15:0] pc, branch_target, jump_target, new_pc;
    logic        halted, ras_empty, ras_full, ras_err;

    int vectors = 0;
    int miscompares = 0;

    // reference model: 0=boot 1=run 2=halted; return stack as a queue
    int          mstate;
    logic [15:0] rq[$];
    bit          merr;
    logic [15:0] e_pc;
    logic        e_halted, e_empty, e_full, e_err;

    next_pc_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
        .new_pc(new_pc), .halted(halted), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_eval();
        e_halted = 1'b0; e_empty = 1'b1; e_full = 1'b0; e_err = 1'b0;
        if (rst) begin
            e_pc = 16'h0000;
            return;
        end
        if (RAS_EN) begin
            e_empty = (rq.size() == 0);
            e_full  = (rq.size() == 4);
            e_err   = merr;
        end
        if (mstate == 0) e_pc = 16'h0000;
        else if (mstate == 2) begin
            e_pc = pc; e_halted = 1'b1;
        end
        else if (halt || stall) e_pc = pc;
        else if (RAS_EN && ret) e_pc = (rq.size() == 0) ? pc + 16'd1 : rq[$];
        else if (call || jump) e_pc = jump_target;
        else if (branch_taken) e_pc = branch_target;
        else e_pc = pc + 16'd1;
    endtask

    task automatic model_update();
        logic [15:0] ra;
        ra = pc + 16'd1;
        if (rst) begin
            mstate = 0; rq.delete(); merr = 1'b0;
        end else if (mstate == 0) begin
            mstate = 1;
        end else if (mstate == 1) begin
            if (halt) mstate = 2;
            else if (stall) ;
            else if (RAS_EN && ret) begin
                if (rq.size() == 0) merr = 1'b1;
                else void'(rq.pop_back());
            end else if (RAS_EN && call) begin
                if (rq.size() == 4) begin
                    void'(rq.pop_front()); merr = 1'b1;
                end
                rq.push_back(ra);
            end
        end
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; halt = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0; tick();
    endtask

    task automatic test_reset();
        idle(); rst = 1; pc = 16'h1234; jump = 1; jump_target = 16'h0777;
        for (int i = 0; i < 2; i++) begin
            settle();
            vectors++;
            if (new_pc !== 16'h0000 || halted !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_out new_pc=%h halted=%b want 0000/0", new_pc, halted);
            end
            vectors++;
            if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_ras e/f/err=%b%b%b want 100", ras_empty, ras_full, ras_err);
            end
            tick();
        end
        rst = 0;
        settle();
        vectors++;
        if (new_pc !== 16'h0000) begin
            miscompares++;
            $display("FAIL boot_cycle new_pc=%h want 0000", new_pc);
        end
        tick();
        jump = 0; pc = 16'h0000;
        settle();
        vectors++;
        if (new_pc !== 16'h0001) begin
            miscompares++;
            $display("FAIL first_seq new_pc=%h want 0001", new_pc);
        end
        tick();
    endtask

    task automatic test_priority();
        idle(); pc = 16'h0010;
        branch_taken = 1; branch_target = 16'h0100;
        settle();
        vectors++;
        if (new_pc !== 16'h0100) begin
            miscompares++;
            $display("FAIL prio_branch new_pc=%h want 0100", new_pc);
        end
        jump = 1; jump_target = 16'h0200;
        settle();
        vectors++;
        if (new_pc !== 16'h0200) begin
            miscompares++;
            $display("FAIL prio_jump new_pc=%h want 0200", new_pc);
        end
        stall = 1;
        settle();
        vectors++;
        if (new_pc !== 16'h0010) begin
            miscompares++;
            $display("FAIL prio_stall new_pc=%h want 0010", new_pc);
        end
        tick();
        idle();
    endtask

    task automatic test_call_ret();
        do_reset();
        call = 1; pc = 16'h0020; jump_target = 16'h0400;
        settle();
        vectors++;
        if (new_pc !== 16'h0400) begin
            miscompares++;
            $display("FAIL call_tgt new_pc=%h want 0400", new_pc);
        end
        tick();
        idle(); ret = 1; pc = 16'h0405;
        settle();
        vectors++;
        if (ras_empty !== !RAS_EN) begin
            miscompares++;
            $display("FAIL call_push ras_empty=%b want %b", ras_empty, !RAS_EN);
        end
        vectors++;
        if (new_pc !== (RAS_EN ? 16'h0021 : 16'h0406)) begin
            miscompares++;
            $display("FAIL ret_tgt new_pc=%h want %h", new_pc,
                     RAS_EN ? 16'h0021 : 16'h0406);
        end
        tick();
        idle(); pc = 16'h0021;
        settle();
        vectors++;
        if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ret_pop empty/err=%b%b want 10", ras_empty, ras_err);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] want;
        idle(); call = 1; jump_target = 16'h0100;
        for (int i = 1; i <= 5; i++) begin
            pc = 16'(i);
            settle();
            if (i == 5) begin
                vectors++;
                if (ras_full !== RAS_EN || ras_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_full full/err=%b%b want %b0", ras_full, ras_err, RAS_EN);
                end
            end
            tick();
        end
        idle(); ret = 1; pc = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            settle();
            want = RAS_EN ? 16'(6 - i) : 16'h0101;
            vectors++;
            if (new_pc !== want) begin
                miscompares++;
                $display("FAIL ovf_ret%0d new_pc=%h want %h", i, new_pc, want);
            end
            tick();
        end
        idle();
        settle();
        vectors++;
        if (ras_empty !== 1'b1 || ras_err !== RAS_EN) begin
            miscompares++;
            $display("FAIL ovf_end empty/err=%b%b want 1%b", ras_empty, ras_err, RAS_EN);
        end
        tick();
    endtask

    task automatic test_underflow();
        do_reset();
        ret = 1; pc = 16'hFFFF;
        settle();
        vectors++;
        if (new_pc !== 16'h0000 || ras_err !== 1'b0) begin
            miscompares++;
            $display("FAIL unf_wrap new_pc=%h err=%b want 0000/0", new_pc, ras_err);
        end
        tick();
        idle(); pc = 16'h0000;
        settle();
        vectors++;
        if (ras_err !== RAS_EN || new_pc !== 16'h0001) begin
            miscompares++;
            $display("FAIL unf_err err=%b new_pc=%h want %b/0001", ras_err, new_pc, RAS_EN);
        end
        tick();
    endtask

    task automatic test_halt();
        idle(); halt = 1; pc = 16'h0033;
        settle();
        vectors++;
        if (new_pc !== 16'h0033) begin
            miscompares++;
            $display("FAIL halt_hold new_pc=%h want 0033", new_pc);
        end
        tick();
        idle(); pc = 16'h0034; jump = 1; call = 1; jump_target = 16'h0999;
        settle();
        vectors++;
        if (new_pc !== 16'h0034 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halted new_pc=%h halted=%b want 0034/1", new_pc, halted);
        end
        tick();
        rst = 1;
        settle();
        vectors++;
        if (new_pc !== 16'h0000 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_rst new_pc=%h halted=%b want 0000/0", new_pc, halted);
        end
        tick();
        rst = 0;
        settle();
        vectors++;
        if (new_pc !== 16'h0000) begin
            miscompares++;
            $display("FAIL halt_boot new_pc=%h want 0000", new_pc);
        end
        tick();
        idle(); pc = 16'h0040;
        settle();
        vectors++;
        if (new_pc !== 16'h0041 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_exit new_pc=%h halted=%b want 0041/0", new_pc, halted);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        e_pc = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 49) == 0);
            halt          = ($urandom_range(0, 79) == 0);
            stall         = ($urandom_range(0, 4) == 0);
            ret           = ($urandom_range(0, 3) == 0);
            call          = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 2) == 0);
            branch_target = 16'($urandom);
            jump_target   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            pc            = ($urandom_range(0, 3) == 0) ? 16'($urandom) : e_pc;
            settle();
            vectors++;
            if (new_pc !== e_pc) begin
                miscompares++;
                $display("FAIL rnd%0d new_pc=%h want %h", i, new_pc, e_pc);
            end
            vectors++;
            if (halted !== e_halted) begin
                miscompares++;
                $display("FAIL rnd%0d halted=%b want %b", i, halted, e_halted);
            end
            vectors++;
            if (ras_empty !== e_empty || ras_full !== e_full) begin
                miscompares++;
                $display("FAIL rnd%0d empty/full=%b%b want %b%b",
                         i, ras_empty, ras_full, e_empty, e_full);
            end
            vectors++;
            if (ras_err !== e_err) begin
                miscompares++;
                $display("FAIL rnd%0d ras_err=%b want %b", i, ras_err, e_err);
            end
            tick();
        end
    endtask

    initial begin
        mstate = 0; merr = 1'b0;
        rst = 1; idle();
        pc = '0; branch_target = '0; jump_target = '0;
        @(negedge clk);
        test_reset();
        test_priority();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
